// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes cpu_addr[31:28] into slots, inserts per-slot wait states, handles ack slaves with timeout.
// Latency: cpu_ready 2+W cycles after the request edge (fixed slots), 1 cycle after the ack edge (ack slots), 1 cycle (undecoded).
// Backpressure: CPU holds the request until the one-cycle cpu_ready pulse; ack slots stall until slv_ack or TIMEOUT.
module mio_bus_ctrl #(
    parameter int          NSLOT    = 16,
    parameter int          DW       = 32,
    parameter logic [63:0] WAITS    = 64'h0,
    parameter logic [15:0] ACK_MASK = 16'h0,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic                clk,
    input  logic                RSTN,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [31:0]         cpu_addr,
    input  logic [DW-1:0]       cpu_wdata,
    output logic [DW-1:0]       cpu_rdata,
    output logic                cpu_ready,
    output logic                cpu_err,
    output logic [NSLOT-1:0]    slv_sel,
    output logic                slv_we,
    output logic [27:0]         slv_addr,
    output logic [DW-1:0]       slv_wdata,
    input  logic [NSLOT*DW-1:0] slv_rdata,
    input  logic [NSLOT-1:0]    slv_ack,
    output logic [7:0]          err_count
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    localparam logic [4:0] NSLOT_W = 5'(NSLOT);

    state_t        state;
    logic [3:0]    slot;
    logic          we_r;
    logic [3:0]    wcnt;
    logic [7:0]    tcnt;
    logic          err_r;
    logic [DW-1:0] rdata_r;

    // Slot-indexed views padded to 16 entries so a 4-bit slot index is always in range.
    logic [DW-1:0] rd_words [16];
    logic [3:0]    wait_tbl [16];
    logic [15:0]   ack_pad;

    for (genvar g = 0; g < 16; g++) begin : g_slot
        assign wait_tbl[g] = WAITS[4*g +: 4];
        if (g < NSLOT) begin : g_live
            assign rd_words[g] = slv_rdata[DW*g +: DW];
            assign ack_pad[g]  = slv_ack[g];
        end else begin : g_pad
            assign rd_words[g] = '0;
            assign ack_pad[g]  = 1'b0;
        end
    end

    function automatic logic [NSLOT-1:0] onehot(input logic [3:0] s);
        logic [15:0] t;
        t = 16'h1 << s;
        return t[NSLOT-1:0];
    endfunction

    logic [3:0] req_slot;
    logic       req_bad;
    logic       access_end;
    logic       timeout_hit;

    assign req_slot    = cpu_addr[31:28];
    assign req_bad     = {1'b0, req_slot} >= NSLOT_W;
    assign access_end  = !ACK_MASK[slot] || ack_pad[slot];
    assign timeout_hit = ({1'b0, tcnt} + 9'd1) >= {1'b0, TIMEOUT};

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            slot      <= '0;
            we_r      <= 1'b0;
            wcnt      <= '0;
            tcnt      <= '0;
            err_r     <= 1'b0;
            rdata_r   <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            slv_sel   <= '0;
            slv_we    <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_ready <= 1'b0;
                    cpu_err   <= 1'b0;
                    if (cpu_req) begin
                        slot      <= req_slot;
                        we_r      <= cpu_we;
                        slv_addr  <= cpu_addr[27:0];
                        slv_wdata <= cpu_wdata;
                        tcnt      <= '0;
                        if (req_bad) begin
                            err_r   <= 1'b1;
                            rdata_r <= '0;
                            state   <= DONE;
                        end else begin
                            err_r <= 1'b0;
                            wcnt  <= wait_tbl[req_slot];
                            if (wait_tbl[req_slot] != 4'd0) begin
                                state <= WAIT;
                            end else begin
                                slv_sel <= onehot(req_slot);
                                slv_we  <= cpu_we;
                                state   <= ACCESS;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (wcnt == 4'd1) begin
                        slv_sel <= onehot(slot);
                        slv_we  <= we_r;
                        state   <= ACCESS;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                ACCESS: begin
                    // A live ack wins over a timeout landing on the same cycle.
                    if (access_end) begin
                        rdata_r <= we_r ? '0 : rd_words[slot];
                        slv_sel <= '0;
                        slv_we  <= 1'b0;
                        state   <= DONE;
                    end else if (timeout_hit) begin
                        err_r   <= 1'b1;
                        rdata_r <= '0;
                        slv_sel <= '0;
                        slv_we  <= 1'b0;
                        state   <= DONE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                DONE: begin
                    cpu_ready <= 1'b1;
                    cpu_err   <= err_r;
                    cpu_rdata <= rdata_r;
                    if (err_r && err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Bench for mio_bus_ctrl: transaction-timeline model checked every cycle, plus hand-computed latency/data checks.
module tb_mio_bus_ctrl;
    localparam logic [63:0] A_WAITS = 64'h3000_0000_0000_0020; // slot15=3, slot1=2
    localparam logic [15:0] A_ACK   = 16'h3000;                // slots 12,13 ack-based
    localparam int          A_TO    = 10;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // DUT A
    logic        cpu_req, cpu_we, cpu_ready, cpu_err, slv_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, slv_wdata;
    logic [15:0] slv_sel, slv_ack;
    logic [27:0] slv_addr;
    logic [7:0]  err_count;
    logic [511:0] slv_rdata;
    logic [31:0] word [16];
    for (genvar g = 0; g < 16; g++) begin : g_a
        assign slv_rdata[32*g +: 32] = word[g];
    end

    mio_bus_ctrl #(.NSLOT(16), .DW(32), .WAITS(A_WAITS), .ACK_MASK(A_ACK), .TIMEOUT(8'(A_TO))) dut_a (
        .clk(clk), .RSTN(rstn), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .slv_sel(slv_sel), .slv_we(slv_we), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
        .slv_rdata(slv_rdata), .slv_ack(slv_ack), .err_count(err_count));

    // DUT B: 8 slots, defaults otherwise
    logic        b_req, b_we, b_ready, b_err, b_slv_we;
    logic [31:0] b_addr, b_wdata, b_rdata, b_slv_wdata;
    logic [7:0]  b_sel, b_ack, b_err_count;
    logic [27:0] b_slv_addr;
    logic [255:0] b_slv_rdata;
    for (genvar g = 0; g < 8; g++) begin : g_b
        assign b_slv_rdata[32*g +: 32] = 32'hB000_0000 | g;
    end

    mio_bus_ctrl #(.NSLOT(8), .DW(32)) dut_b (
        .clk(clk), .RSTN(rstn), .cpu_req(b_req), .cpu_we(b_we), .cpu_addr(b_addr),
        .cpu_wdata(b_wdata), .cpu_rdata(b_rdata), .cpu_ready(b_ready), .cpu_err(b_err),
        .slv_sel(b_sel), .slv_we(b_slv_we), .slv_addr(b_slv_addr), .slv_wdata(b_slv_wdata),
        .slv_rdata(b_slv_rdata), .slv_ack(b_ack), .err_count(b_err_count));

    // Model of the transaction in flight on DUT A, expressed as edge numbers.
    bit          m_act;
    int          m_acc_s, m_acc_e, m_rdy, m_ack_k, m_errcnt;
    logic [15:0] m_sel, m_ack_extra;
    logic        m_we, m_err;
    logic [31:0] m_rdata, m_wdata, m_last_rdata;
    logic [27:0] m_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic start_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                             input int ack_k, input logic [15:0] extra, output int s);
        logic [63:0] wv;
        logic [15:0] am;
        logic [3:0]  sl;
        int          w;
        wv = A_WAITS;
        am = A_ACK;
        sl = addr[31:28];
        s  = edge_n + 1;
        w  = int'(wv[4*sl +: 4]);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        m_act = 1'b1; m_we = we; m_addr = addr[27:0]; m_wdata = wdata;
        m_ack_k = ack_k; m_ack_extra = extra;
        m_sel = 16'h1 << sl;
        m_acc_s = s + w;
        if (!am[sl]) begin
            m_acc_e = m_acc_s + 1; m_err = 1'b0; m_rdata = we ? 32'h0 : word[sl];
        end else if (ack_k >= 1 && ack_k <= A_TO) begin
            m_acc_e = m_acc_s + ack_k; m_err = 1'b0; m_rdata = we ? 32'h0 : word[sl];
        end else begin
            m_acc_e = m_acc_s + A_TO; m_err = 1'b1; m_rdata = 32'h0;
        end
        m_rdy = m_acc_e + 1;
    endtask

    task automatic wait_txn(input bit keep, output int r_edge, output logic [31:0] rd, output logic er);
        r_edge = -1; rd = '0; er = 1'b0;
        for (int g = 0; g < 400 && r_edge < 0; g++) begin
            @(negedge clk);
            slv_ack = m_ack_extra | ((m_ack_k > 0 && edge_n == m_acc_s + m_ack_k - 1) ? m_sel : 16'h0);
            if (cpu_ready) begin
                r_edge = edge_n; rd = cpu_rdata; er = cpu_err;
            end
        end
        slv_ack = 16'h0;
        if (!keep) cpu_req = 1'b0;
        chk("ready_seen", 64'(r_edge >= 0), 64'd1);
    endtask

    task automatic b_txn(input logic [31:0] addr, output int lat, output logic [31:0] rd,
                         output logic er, output logic [7:0] sel_or);
        int s;
        s = edge_n + 1; lat = -1; rd = '0; er = 1'b0; sel_or = '0;
        b_req = 1'b1; b_we = 1'b0; b_addr = addr;
        for (int g = 0; g < 50 && lat < 0; g++) begin
            @(negedge clk);
            sel_or |= b_sel;
            if (b_ready) begin
                lat = edge_n - s; rd = b_rdata; er = b_err;
            end
        end
        b_req = 1'b0;
    endtask

    // Per-cycle comparison of DUT A against the model, sampled 1 time unit after each rising edge.
    initial begin : cmp
        logic in_acc, exp_rdy;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                chk("reset_outputs", 64'({cpu_ready, cpu_err, slv_we, slv_sel, err_count, cpu_rdata}), 64'd0);
                chk("reset_slv_bus", 64'({slv_addr, slv_wdata}), 64'd0);
            end else begin
                in_acc  = m_act && edge_n >= m_acc_s && edge_n < m_acc_e;
                exp_rdy = m_act && edge_n == m_rdy;
                chk("slv_sel", 64'(slv_sel), 64'(in_acc ? m_sel : 16'h0));
                chk("slv_we", 64'(slv_we), 64'(in_acc && m_we));
                if (in_acc) begin
                    chk("slv_addr", 64'(slv_addr), 64'(m_addr));
                    chk("slv_wdata", 64'(slv_wdata), 64'(m_wdata));
                end
                chk("cpu_ready", 64'(cpu_ready), 64'(exp_rdy));
                if (exp_rdy) begin
                    m_last_rdata = m_rdata;
                    if (m_err && m_errcnt < 255) m_errcnt++;
                end
                chk("cpu_err", 64'(cpu_err), 64'(exp_rdy && m_err));
                chk("cpu_rdata", 64'(cpu_rdata), 64'(m_last_rdata));
                chk("err_count", 64'(err_count), 64'(m_errcnt));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, r, lat;
        int rb [4];
        logic [31:0] rd;
        logic er;
        logic [7:0] sel_or;
        logic [31:0] burst_addr [4];

        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; slv_ack = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; b_ack = 0;
        m_act = 0; m_errcnt = 0; m_last_rdata = 0; m_ack_k = 0; m_ack_extra = 0;
        for (int i = 0; i < 16; i++) word[i] = 32'hA000_0000 | i;
        word[14] = 32'h1234_5678;
        word[12] = 32'hCAFE_0001;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Read, no waits
        start_txn(32'hE000_0004, 1'b0, 32'h0, 0, 16'h0, s);
        wait_txn(1'b0, r, rd, er);
        chk("t1_latency", 64'(r - s), 64'd2);
        chk("t1_rdata", 64'(rd), 64'h1234_5678);
        chk("t1_err", 64'(er), 64'd0);

        // Write, 3 wait states
        @(negedge clk);
        start_txn(32'hF000_0010, 1'b1, 32'h0000_00A5, 0, 16'h0, s);
        wait_txn(1'b0, r, rd, er);
        chk("t2_latency", 64'(r - s), 64'd5);
        chk("t2_rdata", 64'(rd), 64'd0);

        // Ack slot, ack sampled 7 cycles into ACCESS, noise on other ack lines
        @(negedge clk);
        start_txn(32'hC000_0000, 1'b0, 32'h0, 7, 16'h2800, s);
        wait_txn(1'b0, r, rd, er);
        chk("t3_latency", 64'(r - s), 64'd8);
        chk("t3_rdata", 64'(rd), 64'hCAFE_0001);

        // Slot 1 with 2 waits and a fresh data word
        word[1] = 32'h5A5A_0101;
        @(negedge clk);
        start_txn(32'h1000_0020, 1'b0, 32'h0, 0, 16'h0, s);
        wait_txn(1'b0, r, rd, er);
        chk("t5_latency", 64'(r - s), 64'd4);
        chk("t5_rdata", 64'(rd), 64'h5A5A_0101);

        // Ack slot that never acks; slot 12 ack held high must be ignored
        @(negedge clk);
        start_txn(32'hD000_0000, 1'b0, 32'h0, 0, 16'h1000, s);
        wait_txn(1'b0, r, rd, er);
        chk("t4_latency", 64'(r - s), 64'd11);
        chk("t4_err", 64'(er), 64'd1);
        chk("t4_rdata", 64'(rd), 64'd0);
        chk("t4_err_count", 64'(err_count), 64'd1);
        for (int i = 0; i < 299; i++) begin
            start_txn(32'hD000_0000, 1'b0, 32'h0, 0, 16'h0, s);
            wait_txn(1'b0, r, rd, er);
        end
        chk("t4_saturated", 64'(err_count), 64'd255);

        // Reset while in WAIT: everything clears at once, no ready for the abandoned access
        @(negedge clk);
        start_txn(32'hF000_0000, 1'b0, 32'h0, 0, 16'h0, s);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        m_act = 0; m_errcnt = 0; m_last_rdata = 0;
        cpu_req = 1'b0;
        #1;
        chk("rst_immediate", 64'({cpu_ready, cpu_err, slv_we, slv_sel, err_count, cpu_rdata}), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Back-to-back burst with cpu_req held high
        burst_addr[0] = 32'hE000_0000;
        burst_addr[1] = 32'h0000_0040;
        burst_addr[2] = 32'h1000_0044;
        burst_addr[3] = 32'hE000_0048;
        for (int i = 0; i < 4; i++) begin
            start_txn(burst_addr[i], 1'b0, 32'h0, 0, 16'h0, s);
            wait_txn(i < 3, rb[i], rd, er);
            chk("burst_rdata", 64'(rd), 64'(word[burst_addr[i][31:28]]));
        end
        chk("burst_gap01", 64'(rb[1] - rb[0]), 64'd3);
        chk("burst_gap12", 64'(rb[2] - rb[1]), 64'd5);
        chk("burst_gap23", 64'(rb[3] - rb[2]), 64'd3);

        // 8-slot instance: undecoded slot, then a normal read
        @(negedge clk);
        b_txn(32'h9000_0000, lat, rd, er, sel_or);
        chk("b_bad_latency", 64'(lat), 64'd1);
        chk("b_bad_err", 64'(er), 64'd1);
        chk("b_bad_rdata", 64'(rd), 64'd0);
        chk("b_bad_sel", 64'(sel_or), 64'd0);
        chk("b_err_count", 64'(b_err_count), 64'd1);
        @(negedge clk);
        b_txn(32'h3000_0000, lat, rd, er, sel_or);
        chk("b_ok_latency", 64'(lat), 64'd2);
        chk("b_ok_rdata", 64'(rd), 64'hB000_0003);
        chk("b_ok_err", 64'(er), 64'd0);
        chk("b_ok_sel", 64'(sel_or), 64'h08);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
- Parametrised successor to the fixed, always-ready memory/IO bus between the MIPS multi-cycle CPU and its peripherals (RAM, GPIO, counters, VRAM, PS2).
- Decodes the CPU address into NSLOT peripheral slots and inserts programmable per-slot wait states.
- Supports acknowledge-based slow slaves with a timeout, and drives the CPU's MIO_ready handshake instead of tying it high.

Parameters:
- NSLOT, 16, number of slots (1..16); slot index = cpu_addr[31:28].
- DW, 32, data width.
- WAITS, 64'h0, packed 4 bits per slot; slot i uses WAITS[4i+3:4i] wait cycles (0..15).
- ACK_MASK, 16'h0, bit i=1: slot i completes only on slv_ack[i]; bit i=0: fixed single-cycle access.
- TIMEOUT, 8'd255, maximum ACCESS cycles for ack slots before error.

Ports:
- clk  in  1  system clock, all logic on rising edge
- RSTN  in  1  asynchronous active-low reset
- cpu_req  in  1  transaction request; CPU holds addr/we/wdata stable until cpu_ready
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  32  byte address
- cpu_wdata  in  DW  write data
- cpu_rdata  out  DW  read data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  error flag, valid with cpu_ready
- slv_sel  out  NSLOT  one-hot slot select
- slv_we  out  1  write strobe, qualified by slv_sel
- slv_addr  out  28  cpu_addr[27:0] latched
- slv_wdata  out  DW  latched write data
- slv_rdata  in  NSLOT*DW  packed slave read data, slot i at [DW*i +: DW]
- slv_ack  in  NSLOT  slave acknowledge (ack slots only)
- err_count  out  8  saturating error counter

Behaviour:
- Reset (RSTN=0, asynchronous): state=IDLE; cpu_ready=0, cpu_err=0, cpu_rdata=0, slv_sel=0, slv_we=0, slv_addr=0, slv_wdata=0, err_count=0; counters cleared. Any transaction in flight is abandoned; no ready is issued for it.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - On cpu_req=1, latch we/addr/wdata and slot = addr[31:28].
  - slot >= NSLOT -> DONE with err=1, rdata=0.
  - Otherwise wait counter = WAITS[slot]; go to WAIT if nonzero, else ACCESS.
- WAIT: counter decrements each cycle; on reaching 1, go to ACCESS. Exactly W cycles are spent in WAIT.
- ACCESS:
  - slv_sel[slot]=1; slv_we=latched we.
  - Non-ack slot: exactly one cycle. Capture slv_rdata slot word at the end of the cycle; go to DONE.
  - Ack slot: hold sel/we until slv_ack[slot]=1, then capture rdata and go to DONE.
  - Ack slot timeout: if TIMEOUT cycles pass without ack, go to DONE with err=1, rdata=0.
  - slv_ack bits of unselected slots are ignored.
- DONE: cpu_ready=1 for exactly one cycle, with cpu_rdata/cpu_err valid (rdata=0 for writes); slv_sel=0; next state IDLE.
- Latency, non-ack slot with W waits: cpu_ready asserts 2+W cycles after the edge that samples cpu_req.
- Latency, ack slot: cpu_ready asserts 1 cycle after the edge sampling slv_ack.
- Back-to-back transactions: CPU may keep cpu_req high. IDLE samples it the cycle after DONE, so there is one idle cycle minimum between transactions.
- cpu_req deasserted mid-transaction: ignored; the transaction completes.
- err_count increments on every error completion and saturates at 255.
- cpu_err is cleared in IDLE. cpu_rdata holds its last value until the next DONE.
- slv_we is never asserted outside ACCESS, and never with slv_sel=0.

Test Plan:
- Reset, then read slot 0xE with WAITS=0, slv_rdata slot14=32'h1234_5678 -> cpu_ready pulses 2 cycles after req; cpu_rdata=32'h1234_5678; cpu_err=0.
- Write slot 0xF, cpu_wdata=32'h0000_00A5, WAITS[63:60]=3 -> slv_sel[15]=1 and slv_we=1 for exactly one cycle, 3 cycles after entering WAIT; slv_wdata=32'hA5; ready 5 cycles after req.
- Ack slot 0xC (ACK_MASK[12]=1), ack raised 7 cycles into ACCESS with rdata 32'hCAFE_0001 -> sel held 7 cycles; ready next cycle; rdata=32'hCAFE_0001.
- Ack slot never acknowledges, TIMEOUT=10 -> ready after 10 ACCESS cycles; cpu_err=1; rdata=0; err_count=1. Repeat 300 times -> err_count=255.
- NSLOT=8, access address 32'h9000_0000 -> no slv_sel activity; ready 1 cycle after req; cpu_err=1.
- RSTN pulsed low during WAIT, then a back-to-back burst of 4 reads with cpu_req held high -> all outputs 0 immediately on reset with no spurious ready; the burst produces 4 ready pulses, each separated by at least one idle cycle.
